// File: rtl/minifloat_divider.sv
// Sequential divider for the 8-bit minifloat format (1s/3e/4f), one quotient bit per clock.
// Optional macro ROUND_NEAREST_EN: extra quotient bit and round-half-up instead of truncation.
module minifloat_divider #(
    parameter int EXP_BIAS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in1,
    input  logic [8:0] in2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out,
    output logic [2:0] out_flags
);

`ifdef ROUND_NEAREST_EN
    localparam int Q_BITS = 7;
`else
    localparam int Q_BITS = 6;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [5:0]          rem_q, rem_d;
    logic [4:0]          div_q, div_d;
    logic [Q_BITS-1:0]   quo_q, quo_d;
    logic [2:0]          count_q, count_d;
    logic                sign_q, sign_d;
    logic [2:0]          e1_q, e1_d, e2_q, e2_d;
    logic                z1_q, z1_d, z2_q, z2_d;
    logic                phase_q, phase_d;
    logic [3:0]          frac_q, frac_d;
    logic [5:0]          exp_q, exp_d;
    logic [8:0]          out_q, out_d;
    logic [2:0]          flags_q, flags_d;

    logic [6:0]          diff;
    logic [5:0]          rem_keep;
    logic [3:0]          frac_t;
    logic                guard;
    logic                adj;
    logic [4:0]          rounded;
    logic [5:0]          e_base;
    logic                unused_bits;

    assign unused_bits = ^{in1[8], in2[8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            z1_q    <= 1'b0;
            z2_q    <= 1'b0;
            phase_q <= 1'b0;
            frac_q  <= '0;
            exp_q   <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            phase_q <= phase_d;
            frac_q  <= frac_d;
            exp_q   <= exp_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    // One restoring step: the kept remainder is always below D, so the shift cannot overflow.
    assign diff     = {1'b0, rem_q} - {2'b00, div_q};
    assign rem_keep = diff[6] ? rem_q : diff[5:0];

    always_comb begin
`ifdef ROUND_NEAREST_EN
        if (quo_q[6]) begin
            frac_t = quo_q[5:2];
            guard  = quo_q[1];
            adj    = 1'b0;
        end else begin
            frac_t = quo_q[4:1];
            guard  = quo_q[0];
            adj    = 1'b1;
        end
`else
        guard = 1'b0;
        if (quo_q[5]) begin
            frac_t = quo_q[4:1];
            adj    = 1'b0;
        end else begin
            frac_t = quo_q[3:0];
            adj    = 1'b1;
        end
`endif
        e_base  = 6'(e1_q) - 6'(e2_q) + 6'(EXP_BIAS) - {5'b0, adj};
        rounded = {1'b0, frac_t} + {4'b0, guard};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        count_d = count_q;
        sign_d  = sign_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        phase_d = phase_q;
        frac_d  = frac_q;
        exp_d   = exp_q;
        out_d   = out_q;
        flags_d = flags_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rem_d   = {2'b01, in1[3:0]};
                    div_d   = {1'b1, in2[3:0]};
                    quo_d   = '0;
                    count_d = '0;
                    sign_d  = in1[7] ^ in2[7];
                    e1_d    = in1[6:4];
                    e2_d    = in2[6:4];
                    z1_d    = (in1[6:0] == 7'd0);
                    z2_d    = (in2[6:0] == 7'd0);
                    phase_d = 1'b0;
                    state_d = ((in1[6:0] == 7'd0) || (in2[6:0] == 7'd0)) ? S_NORM : S_DIV;
                end
            end
            S_DIV: begin
                quo_d   = {quo_q[Q_BITS-2:0], ~diff[6]};
                rem_d   = {rem_keep[4:0], 1'b0};
                count_d = count_q + 3'd1;
                if (count_q == 3'(Q_BITS - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // First cycle normalises/rounds, second applies specials and saturation.
                if (!phase_q) begin
                    frac_d  = rounded[3:0];
                    exp_d   = e_base + {5'b0, rounded[4]};
                    phase_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    flags_d = 3'b000;
                    if (z2_q) begin
                        out_d   = {1'b0, sign_q, 7'h7F};
                        flags_d = 3'b100;
                    end else if (z1_q) begin
                        out_d   = {1'b0, sign_q, 7'h00};
                    end else if ($signed(exp_q) > 6'sd7) begin
                        out_d   = {1'b0, sign_q, 7'h7F};
                        flags_d = 3'b010;
                    end else if ($signed(exp_q) < 6'sd0 || (exp_q == 6'd0 && frac_q == 4'd0)) begin
                        out_d   = {1'b0, sign_q, 7'h00};
                        flags_d = 3'b001;
                    end else begin
                        out_d   = {1'b0, sign_q, exp_q[2:0], frac_q};
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign out_flags = flags_q;

endmodule
